// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out transmitter with a one-word holding
// buffer, so consecutive words stream with no idle cycle between them.
module piso_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             serial_out,
    output logic             frame,
    output logic             first_bit,
    output logic             word_done,
    output logic             busy
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] buf_q;
    logic             buf_full_q;
    logic             transfer;

    assign in_ready = !buf_full_q && !reset;
    assign transfer = in_valid && in_ready;

    // Shift register advanced one position toward the output end
    always_comb begin
        shreg_d = shreg_q;
        if (MSB_FIRST) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin
            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
        end
    end

    // Transmit state machine: load, shift, buffer and chain words
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (transfer) begin
                        shreg_q <= in_data;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt_q != LAST) begin
                        shreg_q <= shreg_d;
                        cnt_q   <= cnt_q + CW'(1);
                        if (transfer) begin
                            buf_q      <= in_data;
                            buf_full_q <= 1'b1;
                        end
                    end else if (buf_full_q) begin
                        shreg_q    <= buf_q;
                        buf_full_q <= 1'b0;
                        cnt_q      <= '0;
                    end else if (transfer) begin
                        // last-bit edge with an empty buffer: chain the new word directly
                        shreg_q <= in_data;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign frame      = (state_q == SHIFT);
    assign serial_out = frame && (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
    assign first_bit  = frame && (cnt_q == '0);
    assign word_done  = frame && (cnt_q == LAST);
    assign busy       = frame || buf_full_q;

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed table plus hand-written multi-cycle sequences
// driving an MSB-first and an LSB-first instance with identical stimulus.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       vld;
    logic [7:0] data;

    logic rdy_m, sout_m, fr_m, fb_m, wd_m, bz_m;
    logic rdy_l, sout_l, fr_l, fb_l, wd_l, bz_l;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(rst), .in_data(data), .in_valid(vld),
        .in_ready(rdy_m), .serial_out(sout_m), .frame(fr_m),
        .first_bit(fb_m), .word_done(wd_m), .busy(bz_m)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(rst), .in_data(data), .in_valid(vld),
        .in_ready(rdy_l), .serial_out(sout_l), .frame(fr_l),
        .first_bit(fb_l), .word_done(wd_l), .busy(bz_l)
    );

    typedef struct {
        logic       rst;
        logic       vld;
        logic [7:0] data;
        logic       rdy;
        logic       sm;
        logic       sl;
        logic       fr;
        logic       fb;
        logic       wd;
        logic       bz;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] sw[0:3];

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply inputs just after the active edge, then wait to the sampling edge.
    task automatic next_cycle(input logic r, input logic v, input logic [7:0] d);
        @(posedge clk);
        #1;
        rst  = r;
        vld  = v;
        data = d;
        @(negedge clk);
    endtask

    task automatic add_row(input logic r, input logic v, input logic [7:0] d,
                           input logic ry, input logic sm, input logic sl,
                           input logic fr, input logic fb, input logic wd,
                           input logic bz);
        vec_t e;
        e.rst = r; e.vld = v; e.data = d; e.rdy = ry; e.sm = sm; e.sl = sl;
        e.fr = fr; e.fb = fb; e.wd = wd; e.bz = bz;
        tbl.push_back(e);
    endtask

    task automatic add_word(input logic [7:0] w);
        add_row(1'b0, 1'b1, w, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 8; j++)
            add_row(1'b0, 1'b0, 8'h00, 1'b1, w[7-j], w[j], 1'b1,
                    (j == 0), (j == 7), 1'b1);
        add_row(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // One bit of a word on both instances: MSB instance sends w[7-j], LSB sends w[j].
    task automatic chk_bit(input string tag, input logic [7:0] w, input int j);
        chk({tag, "_frame"}, fr_m, 1'b1);
        chk({tag, "_sout_m"}, sout_m, w[7-j]);
        chk({tag, "_sout_l"}, sout_l, w[j]);
        chk({tag, "_first"}, fb_m, (j == 0));
        chk({tag, "_done"}, wd_m, (j == 7));
        chk({tag, "_busy"}, bz_m, 1'b1);
    endtask

    task automatic chk_idle(input string tag, input logic exp_rdy);
        chk({tag, "_rdy"}, rdy_m, exp_rdy);
        chk({tag, "_frame"}, fr_m, 1'b0);
        chk({tag, "_sout"}, sout_m, 1'b0);
        chk({tag, "_busy"}, bz_m, 1'b0);
        chk({tag, "_frame_l"}, fr_l, 1'b0);
    endtask

    // Sender holds in_valid and advances to the next word after each accept.
    task automatic run_stream(input string tag, input int n);
        int   idx = 0;
        logic v;
        logic [7:0] w;
        for (int c = 0; c <= 8 * n + 1; c++) begin
            v = (idx < n);
            next_cycle(1'b0, v, v ? sw[idx] : 8'h00);
            chk({tag, "_rdy"}, rdy_m,
                (c <= 1) || (c % 8 == 1) || (c >= 8 * (n - 1) + 1));
            if (c >= 1 && c <= 8 * n) begin
                w = sw[(c - 1) / 8];
                chk_bit(tag, w, (c - 1) % 8);
            end else begin
                chk({tag, "_frame_off"}, fr_m, 1'b0);
                chk({tag, "_sout_off"}, sout_m, 1'b0);
                chk({tag, "_busy_off"}, bz_m, 1'b0);
            end
            if (v && rdy_m) idx++;
        end
        chk_int({tag, "_accepted"}, idx, n);
    endtask

    initial begin
        rst  = 1'b1;
        vld  = 1'b0;
        data = 8'h00;

        // Reset state, single word 0xA5, then 0x01 (shows bit order per instance)
        add_row(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_word(8'hA5);
        add_word(8'h01);
        foreach (tbl[i]) begin
            next_cycle(tbl[i].rst, tbl[i].vld, tbl[i].data);
            chk("tbl_rdy_m", rdy_m, tbl[i].rdy);
            chk("tbl_rdy_l", rdy_l, tbl[i].rdy);
            chk("tbl_sout_m", sout_m, tbl[i].sm);
            chk("tbl_sout_l", sout_l, tbl[i].sl);
            chk("tbl_frame_m", fr_m, tbl[i].fr);
            chk("tbl_frame_l", fr_l, tbl[i].fr);
            chk("tbl_first_m", fb_m, tbl[i].fb);
            chk("tbl_first_l", fb_l, tbl[i].fb);
            chk("tbl_done_m", wd_m, tbl[i].wd);
            chk("tbl_done_l", wd_l, tbl[i].wd);
            chk("tbl_busy_m", bz_m, tbl[i].bz);
            chk("tbl_busy_l", bz_l, tbl[i].bz);
        end

        // Streaming four words back to back
        sw[0] = 8'hAA; sw[1] = 8'hF0; sw[2] = 8'h55; sw[3] = 8'h0F;
        run_stream("stream", 4);

        // Backpressure: 0x3C held while the buffer is full, sent exactly once
        sw[0] = 8'h11; sw[1] = 8'h22; sw[2] = 8'h3C; sw[3] = 8'h00;
        run_stream("bp", 3);

        // Gap: 0xFF, idle with in_valid low, then 0x81
        next_cycle(1'b0, 1'b1, 8'hFF);
        chk_idle("gap_pre", 1'b1);
        for (int j = 0; j < 8; j++) begin
            next_cycle(1'b0, 1'b0, 8'h00);
            chk_bit("gap_ff", 8'hFF, j);
        end
        for (int g = 0; g < 5; g++) begin
            next_cycle(1'b0, 1'b0, 8'h00);
            chk_idle("gap_idle", 1'b1);
        end
        next_cycle(1'b0, 1'b1, 8'h81);
        chk_idle("gap_xfer", 1'b1);
        for (int j = 0; j < 8; j++) begin
            next_cycle(1'b0, 1'b0, 8'h00);
            chk_bit("gap_81", 8'h81, j);
        end
        next_cycle(1'b0, 1'b0, 8'h00);
        chk_idle("gap_post", 1'b1);

        // Reset during bit 3 with 0x22 buffered
        next_cycle(1'b0, 1'b1, 8'h11);
        chk_idle("rst_xfer", 1'b1);
        next_cycle(1'b0, 1'b1, 8'h22);
        chk_bit("rst_b0", 8'h11, 0);
        chk("rst_b0_rdy", rdy_m, 1'b1);
        next_cycle(1'b0, 1'b0, 8'h00);
        chk_bit("rst_b1", 8'h11, 1);
        chk("rst_b1_rdy", rdy_m, 1'b0);
        next_cycle(1'b0, 1'b0, 8'h00);
        chk_bit("rst_b2", 8'h11, 2);
        next_cycle(1'b1, 1'b0, 8'h00);
        chk_bit("rst_b3", 8'h11, 3);
        chk("rst_b3_rdy", rdy_m, 1'b0);
        next_cycle(1'b1, 1'b0, 8'h00);
        chk_idle("rst_held", 1'b0);
        chk("rst_held_rdy_l", rdy_l, 1'b0);
        for (int c = 0; c < 12; c++) begin
            next_cycle(1'b0, 1'b0, 8'h00);
            chk_idle("rst_after", 1'b1);
            chk("rst_after_bz_l", bz_l, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in serial-out transmitter that accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock with a frame qualifier. It sits on the transmit side of the shift-register serial link. It feeds the serial-in receivers with contiguous words and provides an explicit word-start marker. A one-word holding buffer lets a new word be accepted while the current one is shifting, so back-to-back words stream with no idle cycle between them.

## Interface
- WIDTH, 8, word width in bits (≥2)
- MSB_FIRST, 1, 1 = bit WIDTH-1 transmitted first; 0 = bit 0 first

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_data  input  WIDTH  parallel word to transmit
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a word this cycle
- serial_out  output  1  current serial bit; 0 when frame=0
- frame  output  1  serial_out carries a valid data bit
- first_bit  output  1  high with the first bit of each word
- word_done  output  1  high with the last bit of each word
- busy  output  1  frame=1 or holding buffer full

## Operation
- Storage: shift register (WIDTH bits), bit counter (0..WIDTH-1), holding buffer (WIDTH bits) with full flag, state IDLE/SHIFT.
- Transfer occurs on a rising edge where in_valid && in_ready. in_ready = !buf_full && !reset.
- IDLE + transfer: the word loads directly into the shift register, the counter clears, and the state goes to SHIFT. The buffer is not used.
- SHIFT + transfer while counter < WIDTH-1: the word goes to the holding buffer and buf_full is set.
- SHIFT, counter < WIDTH-1: shift one position toward the output end and increment the counter.
- SHIFT, counter == WIDTH-1 (last bit):
  - If buf_full: load the buffer into the shift register, clear buf_full, clear the counter, and stay in SHIFT.
  - Else, if a transfer occurs on this edge: load in_data directly into the shift register, clear the counter, and stay in SHIFT.
  - Else: go to IDLE.
- serial_out = shift-register bit WIDTH-1 (MSB_FIRST=1) or bit 0 (MSB_FIRST=0), gated by frame.
- frame = (state == SHIFT). first_bit = frame && counter == 0. word_done = frame && counter == WIDTH-1.
- in_data and in_valid are ignored when in_ready = 0. The sender must hold them stable.
- Reset while active (any state): abort the current word, discard buffer contents, return to IDLE.

## Timing
- Reset values: in_ready 0 while reset is high and 1 in the first cycle after release. serial_out 0, frame 0, first_bit 0, word_done 0, busy 0.
- Latency: a transfer at edge k puts bit 0 of the word (per MSB_FIRST order) on serial_out in cycle k+1, with frame = 1 and first_bit = 1. The last bit appears in cycle k+WIDTH with word_done = 1.
- Each word occupies exactly WIDTH consecutive frame cycles.
- Back-to-back operation: if the next word is buffered or transferred on the last-bit edge, its first bit follows in the next cycle. The next cycle has first_bit = 1, and frame stays continuously high.
- The buffer is full after an accept in SHIFT, so in_ready is low until the buffered word moves into the shift register. in_ready returns high in the cycle after the last-bit edge.
- In steady streaming, throughput is one word per WIDTH cycles.
- If nothing is pending at the last bit, frame falls in cycle k+WIDTH+1 and serial_out = 0.

## Test plan
- Single word, MSB_FIRST=1: 0xA5 accepted at edge 0 -> serial_out 1,0,1,0,0,1,0,1 in cycles 1–8. frame high for cycles 1–8, first_bit in cycle 1, word_done in cycle 8, frame 0 in cycle 9.
- LSB_FIRST (MSB_FIRST=0): 0x01 -> serial_out 1 in cycle 1, then 0 for cycles 2–8.
- Streaming: 0xAA, 0xF0, 0x55, 0x0F presented with in_valid held and advanced on each transfer -> 32 contiguous frame cycles with the bit sequence matching the concatenated words. first_bit in cycles 1, 9, 17 and 25. in_ready low while the buffer is full.
- Backpressure: in_valid held high with in_data = 0x3C while the buffer is full -> in_ready = 0 and no word is lost or duplicated. 0x3C is transmitted exactly once.
- Reset mid-frame: reset asserted during bit 3 with a word buffered -> next cycle frame 0, busy 0, in_ready 0. After release, in_ready 1, and the buffered word is never transmitted.
- Gap: single word 0xFF, then in_valid low for 5 cycles, then 0x81 -> frame low for the gap with serial_out 0. 0x81 starts with first_bit one cycle after its transfer.
